// File: rtl/relu_requant.sv
// Multi-lane requantiser: rounding arithmetic right shift, then LINEAR/RELU/CLIP
// activation with saturation to OUT_WIDTH. Two-stage valid/ready pipeline plus a
// sticky saturation-event counter.
module relu_requant #(
  parameter int IN_WIDTH  = 26,
  parameter int OUT_WIDTH = 8,
  parameter int LANES     = 4,
  parameter int SHIFT_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SHIFT_W-1:0]           cfg_shift,
  input  logic [1:0]                   cfg_mode,
  input  logic [OUT_WIDTH-2:0]         cfg_clip,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IN_WIDTH-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  input  logic                         sat_clr,
  output logic [15:0]                  sat_cnt
);

  localparam int RW    = IN_WIDTH + 1;
  localparam int CNT_W = $clog2(LANES + 1);
  localparam logic [SHIFT_W-1:0]   SHIFT_MAX = SHIFT_W'(IN_WIDTH - 1);
  localparam logic signed [RW-1:0] MAX_R     = RW'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [RW-1:0] MIN_R     = -MAX_R - RW'(1);

  typedef enum logic [1:0] {
    MODE_LINEAR = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_CLIP   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  logic                  en;
  logic [SHIFT_W-1:0]    shift_c;
  logic signed [RW-1:0]  r_c  [LANES];
  logic signed [RW-1:0]  s1_r [LANES];
  logic                  s1_valid;
  mode_t                 s1_mode;
  logic [OUT_WIDTH-2:0]  s1_clip;
  logic [OUT_WIDTH-1:0]  o_c  [LANES];
  logic [LANES-1:0]      lane_sat;
  logic [CNT_W-1:0]      ev_cnt;
  logic [16:0]           sat_sum;
  logic [15:0]           sat_next;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign shift_c  = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;

  // Stage 1: rounding shift, kept one bit wider so the +1 can never overflow
  always_comb begin
    logic signed [RW-1:0] xe;
    logic signed [RW-1:0] sh;
    logic signed [RW-1:0] sh_h;
    logic                 half;
    xe   = '0;
    sh   = '0;
    sh_h = '0;
    half = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      xe   = {in_data[i*IN_WIDTH + IN_WIDTH - 1], in_data[i*IN_WIDTH +: IN_WIDTH]};
      sh   = xe >>> shift_c;
      sh_h = xe >>> (shift_c - 1'b1);
      half = (shift_c != '0) ? sh_h[0] : 1'b0;
      r_c[i] = sh + $signed({{(RW-1){1'b0}}, half});
    end
  end

  // Stage 2: activation and saturation-event detection
  always_comb begin
    logic signed [RW-1:0] clip_r;
    clip_r   = $signed({{(RW-OUT_WIDTH+1){1'b0}}, s1_clip});
    lane_sat = '0;
    ev_cnt   = '0;
    for (int i = 0; i < LANES; i++) begin
      o_c[i] = s1_r[i][OUT_WIDTH-1:0];
      case (s1_mode)
        MODE_LINEAR: begin
          if (s1_r[i] > MAX_R) begin
            o_c[i] = MAX_R[OUT_WIDTH-1:0];
            lane_sat[i] = 1'b1;
          end else if (s1_r[i] < MIN_R) begin
            o_c[i] = MIN_R[OUT_WIDTH-1:0];
            lane_sat[i] = 1'b1;
          end
        end
        MODE_CLIP: begin
          if (s1_r[i] < 0) begin
            o_c[i] = '0;
          end else if (s1_r[i] > clip_r) begin
            o_c[i] = {1'b0, s1_clip};
            lane_sat[i] = 1'b1;
          end
        end
        default: begin
          if (s1_r[i] < 0) begin
            o_c[i] = '0;
          end else if (s1_r[i] > MAX_R) begin
            o_c[i] = MAX_R[OUT_WIDTH-1:0];
            lane_sat[i] = 1'b1;
          end
        end
      endcase
      ev_cnt = ev_cnt + CNT_W'(lane_sat[i]);
    end
    sat_sum  = {1'b0, sat_cnt} + 17'(ev_cnt);
    sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_r      <= '{default: '0};
      s1_mode   <= MODE_LINEAR;
      s1_clip   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_cnt   <= '0;
    end else begin
      if (en) begin
        s1_valid  <= in_valid;
        s1_r      <= r_c;
        s1_mode   <= mode_t'(cfg_mode);
        s1_clip   <= cfg_clip;
        out_valid <= s1_valid;
        for (int i = 0; i < LANES; i++) out_data[i*OUT_WIDTH +: OUT_WIDTH] <= o_c[i];
      end
      // Clear takes priority over events landing in the same cycle
      if (sat_clr) sat_cnt <= '0;
      else if (en && s1_valid) sat_cnt <= sat_next;
    end
  end

endmodule
